wishbone_arbiter: RTL and testbench

- Round-robin bus arbiter that shares the single shared-bus wishbone interconnect between N_MASTER masters.
- Consumes each master's cyc/stb and the interconnect's muxed ack.
- Produces the one-hot grant that feeds the masters' wb_gnt_i and drives the interconnect's master-side mux select.
- Includes a per-transfer stall watchdog: a granted master that never receives ack is errored out and evicted, so it cannot lock the bus.

---
 rtl/wishbone_arbiter.sv | 124 ++++++++++++
 tb/tb_wishbone_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter for a shared-bus wishbone interconnect with a per-transfer
// stall watchdog that evicts a granted master which never sees ack.
module wishbone_arbiter #(
  parameter int N_MASTER = 2,
  parameter int TIMEOUT  = 16,
  parameter int IDW      = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_MASTER-1:0] cyc_i,
  input  logic [N_MASTER-1:0] stb_i,
  input  logic                ack_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic [IDW-1:0]      gnt_id_o,
  output logic                gnt_valid_o,
  output logic [N_MASTER-1:0] err_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

  state_t              state_q, state_d;
  logic [N_MASTER-1:0] gnt_q, gnt_d;
  logic [N_MASTER-1:0] err_q, err_d;
  logic [N_MASTER-1:0] mask_q, mask_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_MASTER-1:0] elig;
  logic [IDW-1:0]      win;
  logic                found;
  int                  idx;

  // Scan upward from the slot after the last owner, wrapping around.
  always_comb begin
    elig  = cyc_i & ~mask_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= N_MASTER; i++) begin
      idx = (int'(last_q) + i) % N_MASTER;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    err_d   = '0;
    cnt_d   = cnt_q;
    mask_d  = mask_q & cyc_i;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d[win] = 1'b1;
          id_d       = win;
          last_d     = win;
          cnt_d      = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!cyc_i[id_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (TIMEOUT > 0) begin
          // An ack in the final stalled cycle still rescues the transfer.
          if (ack_i || !stb_i[id_q]) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d[id_q]  = 1'b1;
            mask_d[id_q] = 1'b1;
            gnt_d        = '0;
            cnt_d        = '0;
            state_d      = HOLDOFF;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLDOFF: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      last_q  <= IDW'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = |gnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench: a 2-master arbiter with a short watchdog and a 4-master
// arbiter sharing clock and reset.
module tb_wishbone_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cyc2 = '0, stb2 = '0;
  logic       ack2 = 1'b0;
  logic [1:0] gnt2, err2;
  logic       id2, vld2;
  logic [3:0] cyc4 = '0, stb4 = '0;
  logic [3:0] gnt4, err4;
  logic [1:0] id4;
  logic       vld4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wishbone_arbiter #(.N_MASTER(2), .TIMEOUT(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc2), .stb_i(stb2), .ack_i(ack2),
    .gnt_o(gnt2), .gnt_id_o(id2), .gnt_valid_o(vld2), .err_o(err2)
  );

  wishbone_arbiter #(.N_MASTER(4), .TIMEOUT(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc4), .stb_i(stb4), .ack_i(1'b0),
    .gnt_o(gnt4), .gnt_id_o(id4), .gnt_valid_o(vld4), .err_o(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] g, input logic id,
                      input logic [1:0] e);
    chk({tag, ".gnt"}, 32'(gnt2), 32'(g));
    chk({tag, ".vld"}, 32'(vld2), 32'(|g));
    chk({tag, ".id"},  32'(id2),  32'(id));
    chk({tag, ".err"}, 32'(err2), 32'(e));
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".gnt"}, 32'(gnt4), 32'(g));
    chk({tag, ".vld"}, 32'(vld4), 32'(|g));
    chk({tag, ".id"},  32'(id4),  32'(id));
    chk({tag, ".err"}, 32'(err4), 32'h0);
  endtask

  initial begin
    logic [1:0] ex;
    logic [3:0] oh;
    // reset state
    tick(); tick();
    chk2("rst2", 2'b00, 1'b0, 2'b00);
    chk4("rst4", 4'b0000, 2'd0);
    rst = 1'b0;

    // 4 masters, 1 and 3 requesting with 2-cycle transfers
    cyc4 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      ex = (k % 2 == 1) ? 2'd3 : 2'd1;
      oh = 4'b0001 << ex;
      tick(); chk4("rr4.g", oh, ex);
      tick(); chk4("rr4.h", oh, ex);
      cyc4 = 4'b1010 & ~oh;
      tick(); chk4("rr4.d", 4'b0000, ex);
      cyc4 = 4'b1010;
    end
    cyc4 = 4'b0000;

    // single requester: latency, hold, release
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    cyc2 = 2'b01;
    tick(); chk2("one.gnt", 2'b01, 1'b0, 2'b00);
    tick(); tick(); tick(); tick();
    chk2("one.hold", 2'b01, 1'b0, 2'b00);
    cyc2 = 2'b00;
    tick(); chk2("one.rel", 2'b00, 1'b0, 2'b00);

    // two requesters alternate 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    cyc2 = 2'b11;
    tick(); chk2("alt.g0", 2'b01, 1'b0, 2'b00);
    tick(); chk2("alt.h0", 2'b01, 1'b0, 2'b00);
    cyc2 = 2'b10;
    tick(); chk2("alt.dead0", 2'b00, 1'b0, 2'b00);
    tick(); chk2("alt.g1", 2'b10, 1'b1, 2'b00);
    cyc2 = 2'b11;
    tick(); chk2("alt.h1", 2'b10, 1'b1, 2'b00);
    cyc2 = 2'b01;
    tick(); chk2("alt.dead1", 2'b00, 1'b1, 2'b00);
    tick(); chk2("alt.g0b", 2'b01, 1'b0, 2'b00);
    cyc2 = 2'b10;
    tick(); chk2("alt.dead2", 2'b00, 1'b0, 2'b00);
    tick(); chk2("alt.g1b", 2'b10, 1'b1, 2'b00);
    cyc2 = 2'b00;
    tick(); chk2("alt.rel", 2'b00, 1'b1, 2'b00);

    // watchdog eviction of master 0 while master 1 waits
    cyc2 = 2'b11; stb2 = 2'b01;
    tick(); chk2("wd.g", 2'b01, 1'b0, 2'b00);
    tick(); tick(); tick();
    chk2("wd.stall3", 2'b01, 1'b0, 2'b00);
    tick(); chk2("wd.err", 2'b00, 1'b0, 2'b01);
    tick(); chk2("wd.hold", 2'b00, 1'b0, 2'b00);
    tick(); chk2("wd.g1", 2'b10, 1'b1, 2'b00);
    cyc2 = 2'b01; stb2 = 2'b00;
    tick(); chk2("wd.rel1", 2'b00, 1'b1, 2'b00);
    tick(); chk2("wd.masked", 2'b00, 1'b1, 2'b00);
    cyc2 = 2'b00;
    tick();
    cyc2 = 2'b01;
    tick(); chk2("wd.regrant", 2'b01, 1'b0, 2'b00);
    cyc2 = 2'b00;
    tick(); chk2("wd.rel0", 2'b00, 1'b0, 2'b00);

    // ack on the final stalled cycle rescues the transfer and clears the count
    cyc2 = 2'b01; stb2 = 2'b01;
    tick(); chk2("ack.g", 2'b01, 1'b0, 2'b00);
    tick(); tick(); tick();
    ack2 = 1'b1;
    tick(); chk2("ack.noerr", 2'b01, 1'b0, 2'b00);
    ack2 = 1'b0;
    tick(); tick(); tick();
    chk2("ack.stall3", 2'b01, 1'b0, 2'b00);
    tick(); chk2("ack.err", 2'b00, 1'b0, 2'b01);
    cyc2 = 2'b00; stb2 = 2'b00;
    tick(); tick();

    // reset in the middle of a grant
    cyc2 = 2'b10;
    tick(); chk2("mid.g1", 2'b10, 1'b1, 2'b00);
    cyc2 = 2'b11; stb2 = 2'b10; rst = 1'b1;
    tick(); chk2("mid.rst", 2'b00, 1'b0, 2'b00);
    rst = 1'b0;
    tick(); chk2("mid.g0", 2'b01, 1'b0, 2'b00);
    cyc2 = 2'b00; stb2 = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
